// File: rtl/load_store_unit.sv
// load_store_unit
//   Load/store unit for the single-cycle core. Uses the ALU result as the
//   effective address, checks alignment, builds byte enables and replicated
//   store data, runs one req/ack transaction on the data bus and returns the
//   extended load result. The core is stalled through LSUbusy meanwhile.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   LSUaddress          effective address
//   LSUwriteData        store data (rs2)
//   LSUfunc3            000 B, 001 H, 010 W, 100 BU, 101 HU
//   LSUread / LSUwrite  request strobes (write wins when both high)
//   LSUreadData         extended load result (held between loads)
//   LSUbusy             stall request to the core
//   LSUdone / LSUfault  one-cycle completion / fault pulses
//   MEMreq..MEMbe       data-bus request outputs
//   MEMrdata, MEMack    data-bus response inputs
//
// Optional feature
//   LSU_TIMEOUT_EN: when defined, WAIT gives up after TIMEOUT_CYCLES cycles
//   without MEMack and completes with LSUfault=1.
//
// State | Meaning
// IDLE  | no access in flight, strobes sampled each edge
// WAIT  | bus request held until MEMack
// RESP  | one-cycle LSUdone (and LSUfault) pulse
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] LSUaddress,
    input  logic [31:0] LSUwriteData,
    input  logic [2:0]  LSUfunc3,
    input  logic        LSUread,
    input  logic        LSUwrite,
    output logic [31:0] LSUreadData,
    output logic        LSUbusy,
    output logic        LSUdone,
    output logic        LSUfault,
    output logic        MEMreq,
    output logic        MEMwe,
    output logic [31:0] MEMaddr,
    output logic [31:0] MEMwdata,
    output logic [3:0]  MEMbe,
    input  logic [31:0] MEMrdata,
    input  logic        MEMack
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    logic        strobe;
    logic        req_fault;
    logic        in_wait;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] lane;
    logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign strobe  = LSUread | LSUwrite;
    assign in_wait = (state_q == WAIT);

    // Request legality is judged on the live inputs; a write wins a double strobe.
    always_comb begin
        req_fault = 1'b0;
        case (LSUfunc3)
            3'b000:         req_fault = 1'b0;
            3'b001, 3'b101: req_fault = LSUaddress[0];
            3'b010:         req_fault = (LSUaddress[1:0] != 2'b00);
            3'b100:         req_fault = 1'b0;
            default:        req_fault = 1'b1;
        endcase
        if (LSUfunc3[2] && LSUwrite) begin
            req_fault = 1'b1;
        end
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        lane     = MEMrdata >> {addr_q[1:0], 3'b000};
        load_ext = lane;
        case (func3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wdata_d = wdata_q;
        write_d = write_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (strobe) begin
                    addr_d  = LSUaddress;
                    func3_d = LSUfunc3;
                    wdata_d = LSUwriteData;
                    write_d = LSUwrite;
                    if (req_fault) begin
                        state_d = RESP;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = WAIT;
                        fault_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (MEMack) begin
                    state_d = RESP;
                    if (!write_q) begin
                        rdata_d = load_ext;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Bus outputs are zero outside WAIT so nothing leaks onto the bus.
    assign MEMreq      = in_wait;
    assign MEMwe       = in_wait & write_q;
    assign MEMaddr     = in_wait ? {addr_q[31:2], 2'b00} : 32'd0;
    assign MEMbe       = in_wait ? be : 4'd0;
    assign MEMwdata    = in_wait ? wdata_rep : 32'd0;

    // Gated by rst_n so the stall is also released while reset is held.
    assign LSUbusy     = rst_n & (((state_q == IDLE) & strobe) | in_wait);
    assign LSUdone     = (state_q == RESP);
    assign LSUfault    = (state_q == RESP) & fault_q;
    assign LSUreadData = rdata_q;

endmodule
